pipe_ctrl_chain: RTL and testbench

Parametrised multi-stage control-signal pipeline: it replaces the fixed per-boundary control registers (decode→execute, execute→memory, memory→writeback) with one chain of STAGES registers of WIDTH bits. Each stage carries a valid bit and has its own stall and flush, and the block provides retire and bubble counters. It sits between the controller (decode-stage control word) and the datapath, which reads every stage's control word. Stall and flush requests come from the hazard logic.

---
 rtl/pipe_ctrl_chain.sv | 133 +++++++++++++
 tb/tb_pipe_ctrl_chain.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_chain.sv
// pipe_ctrl_chain
//
// Control-signal pipeline that replaces the fixed decode->execute,
// execute->memory and memory->writeback control registers with a single
// chain of STAGES registers. Each stage has a valid bit, its own stall and
// its own flush. Retire and bubble counters observe the last stage.
//
// Ports:
//   clk          rising-edge clock
//   n_rst        asynchronous active-low reset
//   in_valid     decode-stage word is a real instruction
//   in_ctrl      decode-stage control word (WIDTH bits)
//   in_ready     stage 0 accepts this cycle (combinational, ~|stall)
//   stall        per-stage hold request; a stall at stage k also freezes 0..k-1
//   flush        per-stage flush; the value written into stage i becomes a bubble
//   cnt_clr      synchronous clear of both counters (beats increment)
//   stage_valid  registered valid bit per stage
//   stage_ctrl   registered control words, stage i at [i*WIDTH +: WIDTH]
//   retire_cnt   words leaving the last stage, wraps modulo 2^CNT_W
//   bubble_cnt   cycles with the last stage invalid, wraps modulo 2^CNT_W
//
// Legal STAGES range is 1..8.

module pipe_ctrl_chain #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 3,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_ctrl,
  output logic                      in_ready,
  input  logic [STAGES-1:0]         stall,
  input  logic [STAGES-1:0]         flush,
  input  logic                      cnt_clr,
  output logic [STAGES-1:0]         stage_valid,
  output logic [STAGES*WIDTH-1:0]   stage_ctrl,
  output logic [CNT_W-1:0]          retire_cnt,
  output logic [CNT_W-1:0]          bubble_cnt
);

  localparam int unsigned CtrlW = STAGES * WIDTH;

  logic [STAGES-1:0] valid_q, valid_d;
  logic [CtrlW-1:0]  ctrl_q, ctrl_d;

  // hold[i]: stage i is frozen because it or some downstream stage stalls.
  logic [STAGES-1:0] hold;
  // hold_up[i] = hold[i-1]; bit 0 is always 0, so stage 0 never gets a
  // bubble inserted (and STAGES=1 naturally has no bubble-insertion rule).
  logic [STAGES-1:0] hold_up;
  // Source for each stage: stage i-1 for i>0, the decode word for stage 0.
  logic [STAGES-1:0] src_valid;
  logic [CtrlW-1:0]  src_ctrl;

  logic              retire_ev;
  logic              bubble_ev;
  logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    hold = '0;
    for (int i = 0; i < int'(STAGES); i++) begin
      hold[i] = |(stall >> i);
    end
  end

  assign hold_up   = hold << 1;
  assign src_valid = (valid_q << 1) | STAGES'(in_valid);
  assign src_ctrl  = (ctrl_q << WIDTH) | CtrlW'(in_ctrl);

  // Stage 0 is held exactly when any stage stalls.
  assign in_ready = ~|stall;

  // Per-stage next state, first matching rule wins:
  // flush, hold, bubble behind a held upstream stage, load from source.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    for (int i = 0; i < int'(STAGES); i++) begin
      if (flush[i]) begin
        valid_d[i]                = 1'b0;
        ctrl_d[i*WIDTH +: WIDTH]  = '0;
      end else if (hold[i]) begin
        valid_d[i]                = valid_q[i];
        ctrl_d[i*WIDTH +: WIDTH]  = ctrl_q[i*WIDTH +: WIDTH];
      end else if (hold_up[i]) begin
        valid_d[i]                = 1'b0;
        ctrl_d[i*WIDTH +: WIDTH]  = '0;
      end else begin
        valid_d[i]                = src_valid[i];
        // Zero the word of an invalid source so bubbles never carry enables.
        ctrl_d[i*WIDTH +: WIDTH]  = src_valid[i] ? src_ctrl[i*WIDTH +: WIDTH] : '0;
      end
    end
  end

  assign retire_ev = valid_q[STAGES-1] & ~stall[STAGES-1] & ~flush[STAGES-1];
  assign bubble_ev = ~valid_q[STAGES-1];

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (cnt_clr) begin
      retire_cnt_d = '0;
      bubble_cnt_d = '0;
    end else begin
      retire_cnt_d = retire_cnt_q + CNT_W'(retire_ev);
      bubble_cnt_d = bubble_cnt_q + CNT_W'(bubble_ev);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      valid_q      <= '0;
      ctrl_q       <= '0;
      retire_cnt_q <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      ctrl_q       <= ctrl_d;
      retire_cnt_q <= retire_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stage_valid = valid_q;
  assign stage_ctrl  = ctrl_q;
  assign retire_cnt  = retire_cnt_q;
  assign bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Bench for pipe_ctrl_chain (STAGES=3, WIDTH=8, CNT_W=4).
// Stimulus pushes the expected post-edge state into a queue; a monitor
// pops one entry per clock edge and compares it with the DUT.

`timescale 1ns/1ps

module tb_pipe_ctrl_chain;

  localparam int S  = 3;
  localparam int W  = 8;
  localparam int CW = 4;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             in_valid;
  logic [W-1:0]     in_ctrl;
  logic             in_ready;
  logic [S-1:0]     stall;
  logic [S-1:0]     flush;
  logic             cnt_clr;
  logic [S-1:0]     stage_valid;
  logic [S*W-1:0]   stage_ctrl;
  logic [CW-1:0]    retire_cnt;
  logic [CW-1:0]    bubble_cnt;

  always #5 clk = ~clk;

  pipe_ctrl_chain #(
    .WIDTH  (W),
    .STAGES (S),
    .CNT_W  (CW)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .in_valid    (in_valid),
    .in_ctrl     (in_ctrl),
    .in_ready    (in_ready),
    .stall       (stall),
    .flush       (flush),
    .cnt_clr     (cnt_clr),
    .stage_valid (stage_valid),
    .stage_ctrl  (stage_ctrl),
    .retire_cnt  (retire_cnt),
    .bubble_cnt  (bubble_cnt)
  );

  typedef struct packed {
    logic [S-1:0]   v;
    logic [S*W-1:0] c;
    logic [CW-1:0]  r;
    logic [CW-1:0]  b;
  } snap_t;

  snap_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: list of slots, slot i = stage i.
  logic         m_valid [S];
  logic [W-1:0] m_ctrl  [S];
  int unsigned  m_ret;
  int unsigned  m_bub;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < S; i++) begin
      m_valid[i] = 1'b0;
      m_ctrl[i]  = '0;
    end
    m_ret = 0;
    m_bub = 0;
  endtask

  task automatic model_edge(input logic v, input logic [W-1:0] c, input logic [S-1:0] st,
                            input logic [S-1:0] fl, input logic clr);
    logic         nv [S];
    logic [W-1:0] nc [S];
    bit           frozen;
    bit           up_frozen;
    logic         sv;
    logic [W-1:0] sc;
    bit           leaves;
    leaves = m_valid[S-1] && !st[S-1] && !fl[S-1];
    if (clr) begin
      m_ret = 0;
      m_bub = 0;
    end else begin
      m_ret = (m_ret + (leaves ? 1 : 0)) % (1 << CW);
      m_bub = (m_bub + (m_valid[S-1] ? 0 : 1)) % (1 << CW);
    end
    for (int i = 0; i < S; i++) begin
      frozen = 1'b0;
      for (int j = i; j < S; j++) if (st[j]) frozen = 1'b1;
      up_frozen = 1'b0;
      if (i > 0) for (int j = i - 1; j < S; j++) if (st[j]) up_frozen = 1'b1;
      if (i == 0) begin
        sv = v;
        sc = c;
      end else begin
        sv = m_valid[i-1];
        sc = m_ctrl[i-1];
      end
      if (fl[i]) begin
        nv[i] = 1'b0; nc[i] = '0;
      end else if (frozen) begin
        nv[i] = m_valid[i]; nc[i] = m_ctrl[i];
      end else if (up_frozen) begin
        nv[i] = 1'b0; nc[i] = '0;
      end else begin
        nv[i] = sv; nc[i] = sv ? sc : '0;
      end
    end
    for (int i = 0; i < S; i++) begin
      m_valid[i] = nv[i];
      m_ctrl[i]  = nc[i];
    end
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    for (int i = 0; i < S; i++) begin
      s.v[i]         = m_valid[i];
      s.c[i*W +: W]  = m_ctrl[i];
    end
    s.r = CW'(m_ret);
    s.b = CW'(m_bub);
    return s;
  endfunction

  // Drive one edge's worth of inputs at the falling edge, queue the
  // expected result, and return shortly after the rising edge.
  task automatic step(input logic v, input logic [W-1:0] c, input logic [S-1:0] st,
                      input logic [S-1:0] fl, input logic clr);
    @(negedge clk);
    in_valid = v;
    in_ctrl  = c;
    stall    = st;
    flush    = fl;
    cnt_clr  = clr;
    #1;
    check("in_ready", 64'(in_ready), 64'(st == '0));
    model_edge(v, c, st, fl, clr);
    exp_q.push_back(model_snap());
    @(posedge clk);
    #3;
  endtask

  function automatic logic [W-1:0] dctrl(input int i);
    return stage_ctrl[i*W +: W];
  endfunction

  // Monitor: one expected state per clock edge.
  snap_t mon_e;
  logic  inv_ok;
  always @(posedge clk) begin
    #2;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("mon_stage_valid", 64'(stage_valid), 64'(mon_e.v));
      check("mon_stage_ctrl",  64'(stage_ctrl),  64'(mon_e.c));
      check("mon_retire_cnt",  64'(retire_cnt),  64'(mon_e.r));
      check("mon_bubble_cnt",  64'(bubble_cnt),  64'(mon_e.b));
      inv_ok = 1'b1;
      for (int i = 0; i < S; i++)
        if (!stage_valid[i] && stage_ctrl[i*W +: W] != '0) inv_ok = 1'b0;
      check("mon_invalid_zero", 64'(inv_ok), 64'd1);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic           rv;
    logic [W-1:0]   rc;
    logic [S-1:0]   rst_v;
    logic [S-1:0]   rfl;
    logic           rclr;
    logic           prev_ready;
    int unsigned    ret_before;

    n_rst    = 1'b1;
    in_valid = 1'b0;
    in_ctrl  = '0;
    stall    = '0;
    flush    = '0;
    cnt_clr  = 1'b0;
    model_reset();

    // Asynchronous reset before any clock edge.
    #2 n_rst = 1'b0;
    #1;
    check("rst_valid",  64'(stage_valid), 64'd0);
    check("rst_ctrl",   64'(stage_ctrl),  64'd0);
    check("rst_retire", 64'(retire_cnt),  64'd0);
    check("rst_bubble", 64'(bubble_cnt),  64'd0);
    check("rst_ready",  64'(in_ready),    64'd1);
    repeat (2) @(posedge clk);
    #3 n_rst = 1'b1;

    // Streaming 0x11/0x22/0x33.
    step(1'b1, 8'h11, '0, '0, 1'b0);
    step(1'b1, 8'h22, '0, '0, 1'b0);
    step(1'b1, 8'h33, '0, '0, 1'b0);
    check("stream_s2_11", 64'(dctrl(2)), 64'h11);
    check("stream_v2",    64'(stage_valid[2]), 64'd1);
    step(1'b0, 8'h00, '0, '0, 1'b0);
    check("stream_s2_22", 64'(dctrl(2)), 64'h22);
    step(1'b0, 8'h00, '0, '0, 1'b0);
    check("stream_s2_33", 64'(dctrl(2)), 64'h33);
    step(1'b0, 8'h00, '0, '0, 1'b0);
    check("stream_retire3", 64'(retire_cnt), 64'd3);
    check("stream_bubble3", 64'(bubble_cnt), 64'd3);

    // Refill, then stall stage 1 for two edges.
    step(1'b1, 8'h11, '0, '0, 1'b0);
    step(1'b1, 8'h22, '0, '0, 1'b0);
    step(1'b1, 8'h33, '0, '0, 1'b0);
    ret_before = m_ret;
    step(1'b1, 8'h44, 3'b010, '0, 1'b0);
    check("stall_s2_valid", 64'(stage_valid[2]), 64'd0);
    check("stall_s2_ctrl",  64'(dctrl(2)), 64'h00);
    step(1'b1, 8'h44, 3'b010, '0, 1'b0);
    check("stall_s0_keep", 64'(dctrl(0)), 64'h33);
    check("stall_s1_keep", 64'(dctrl(1)), 64'h22);
    check("stall_retire",  64'(retire_cnt), 64'((ret_before + 1) % 16));

    // Flush beats stall on stage 0.
    step(1'b1, 8'h44, 3'b010, 3'b001, 1'b0);
    check("flush_s0_valid", 64'(stage_valid[0]), 64'd0);
    check("flush_s0_ctrl",  64'(dctrl(0)), 64'h00);
    check("flush_s1_held",  64'(dctrl(1)), 64'h22);
    step(1'b1, 8'h44, '0, '0, 1'b0);
    step(1'b1, 8'h45, '0, '0, 1'b0);

    // Flush at the input.
    step(1'b1, 8'hFF, '0, 3'b001, 1'b0);
    check("flush_in_valid", 64'(stage_valid[0]), 64'd0);
    check("flush_in_ctrl",  64'(dctrl(0)), 64'h00);
    repeat (3) step(1'b0, 8'h00, '0, '0, 1'b0);

    // Randomised traffic; upstream holds its word while in_ready is low.
    prev_ready = 1'b1;
    rv = 1'b0;
    rc = '0;
    for (int k = 0; k < 400; k++) begin
      if (prev_ready) begin
        rv = ($urandom_range(0, 3) != 0);
        rc = W'($urandom);
      end
      for (int b = 0; b < S; b++) begin
        rst_v[b] = ($urandom_range(0, 5) == 0);
        rfl[b]   = ($urandom_range(0, 7) == 0);
      end
      rclr = ($urandom_range(0, 31) == 0);
      step(rv, rc, rst_v, rfl, rclr);
      prev_ready = (rst_v == '0);
    end

    // Asynchronous reset with every stage valid.
    step(1'b1, 8'h51, '0, '0, 1'b0);
    step(1'b1, 8'h52, '0, '0, 1'b0);
    step(1'b1, 8'h53, '0, '0, 1'b0);
    n_rst = 1'b0;
    model_reset();
    #1;
    check("arst_valid",  64'(stage_valid), 64'd0);
    check("arst_ctrl",   64'(stage_ctrl),  64'd0);
    check("arst_retire", 64'(retire_cnt),  64'd0);
    check("arst_bubble", 64'(bubble_cnt),  64'd0);
    n_rst = 1'b1;
    step(1'b1, 8'h44, '0, '0, 1'b0);
    step(1'b0, 8'h00, '0, '0, 1'b0);
    check("arst_s2_not_yet", 64'(stage_valid[2]), 64'd0);
    step(1'b0, 8'h00, '0, '0, 1'b0);
    check("arst_s2_44", 64'(dctrl(2)), 64'h44);

    // Counter wrap at CNT_W=4, then clear coinciding with a retire.
    repeat (3) step(1'b1, 8'h60, '0, '0, 1'b1);
    check("wrap_cleared", 64'(retire_cnt), 64'd0);
    for (int k = 0; k < 15; k++) step(1'b1, W'(k + 1), '0, '0, 1'b0);
    check("wrap_15", 64'(retire_cnt), 64'd15);
    step(1'b1, 8'h70, '0, '0, 1'b0);
    check("wrap_to_0", 64'(retire_cnt), 64'd0);
    step(1'b1, 8'h71, '0, '0, 1'b1);
    check("clr_over_retire", 64'(retire_cnt), 64'd0);
    check("clr_bubble",      64'(bubble_cnt), 64'd0);

    repeat (2) step(1'b0, 8'h00, '0, '0, 1'b0);
    @(posedge clk);
    #4;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
